// File: rtl/mcp3_ram512x064_fifo_ctl.sv
// FIFO controller for a 512x64 simple-dual-port BRAM with a 2-cycle registered read.
// Tracks pointers/occupancy and hides the read latency behind a small prefetch buffer.
module mcp3_ram512x064_fifo_ctl #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 64,
  parameter int OBUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_wrad,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_rden,
  output logic [ADDR_W-1:0] ram_rdad,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W:0]   occupancy,
  output logic              err_collide,
  output logic [1:0]        dbg_state
);

  // Handshake: a word moves on a side only in a cycle where valid and ready are both 1;
  // valid never depends on ready of the same side.

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam int OB_AW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int OB_CW = $clog2(OBUF_DEPTH + 1);
  localparam int CR_W  = OB_CW + 1;

  typedef enum logic [1:0] {S_RUN = 2'd0, S_FL1 = 2'd1, S_FL2 = 2'd2} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    ram_cnt;
  logic                v1, v2;
  logic [DATA_W-1:0]   obuf [OBUF_DEPTH];
  logic [OB_AW-1:0]    ob_wr, ob_rd;
  logic [OB_CW-1:0]    ob_cnt;
  logic                err_q;

  logic                run, push, pop, capture;
  logic [CR_W-1:0]     credit;

  assign out_valid   = (ob_cnt != '0);
  assign out_data    = obuf[ob_rd];
  assign pop         = out_valid && out_ready;
  assign push        = in_valid && in_ready;
  // Reads already issued or buffered; bounds issue so the prefetch buffer can never overflow.
  assign credit      = CR_W'(v1) + CR_W'(v2) + CR_W'(ob_cnt) - CR_W'(pop);
  assign ram_wren    = push;
  assign ram_wrad    = wr_ptr;
  assign ram_data    = in_data;
  assign ram_rdad    = rd_ptr;
  assign occupancy   = ram_cnt + CNT_W'(v1) + CNT_W'(v2) + CNT_W'(ob_cnt);
  assign err_collide = err_q;
  assign dbg_state   = state;

  // State register plus datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_RUN;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      ob_wr   <= '0;
      ob_rd   <= '0;
      ob_cnt  <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < OBUF_DEPTH; i++) obuf[i] <= '0;
    end else begin
      state <= state_nxt;
      v1    <= ram_rden;
      v2    <= v1;
      if (flush && state == S_RUN) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        ram_cnt <= '0;
        ob_wr   <= '0;
        ob_rd   <= '0;
        ob_cnt  <= '0;
      end else begin
        if (push)     wr_ptr <= wr_ptr + ADDR_W'(1);
        if (ram_rden) rd_ptr <= rd_ptr + ADDR_W'(1);
        ram_cnt <= ram_cnt + CNT_W'(push) - CNT_W'(ram_rden);
        if (capture) begin
          obuf[ob_wr] <= ram_q;
          ob_wr <= (ob_wr == OB_AW'(OBUF_DEPTH - 1)) ? '0 : ob_wr + OB_AW'(1);
        end
        if (pop) ob_rd <= (ob_rd == OB_AW'(OBUF_DEPTH - 1)) ? '0 : ob_rd + OB_AW'(1);
        ob_cnt <= ob_cnt + OB_CW'(capture) - OB_CW'(pop);
      end
      if (ram_rden && ram_wren && (ram_rdad == ram_wrad)) err_q <= 1'b1;
    end
  end

  // Reads are never issued in the flush cycle, so two FLUSH cycles always drain v1/v2.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:   if (flush) state_nxt = S_FL1;
      S_FL1:   state_nxt = S_FL2;
      S_FL2:   if (!v1 && !v2) state_nxt = S_RUN;
      default: state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    run      = (state == S_RUN) && !reset;
    in_ready = run && (ram_cnt < CNT_W'(DEPTH));
    ram_rden = run && !flush && (ram_cnt != '0) && (credit < CR_W'(OBUF_DEPTH));
    capture  = v2 && (state == S_RUN);
  end

endmodule
